btzk_i2c_slave: RTL and testbench

I2C target (responder) that answers the `btzk_i2c` controller on the same two-wire bus. It oversamples SCL/SDA with the system clock, detects START/STOP, matches a fixed 7-bit address, and hands received bytes to the fabric or serves bytes from it for reads. Used for on-board loopback of the controller and as the FPGA-side register port for an external host.

---
 rtl/btzk_i2c_pkg.sv | 19 +
 rtl/btzk_i2c_sync_edge.sv | 31 +++
 rtl/btzk_i2c_slave.sv | 186 ++++++++++++++++++
 tb/tb_btzk_i2c_slave.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/btzk_i2c_pkg.sv
// Shared widths and state encoding for the btzk I2C controller/target pair.
package btzk_i2c_pkg;

  localparam int unsigned I2C_ADDR_W  = 7;
  localparam int unsigned I2C_BYTE_W  = 8;
  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StAddr     = 3'd1,
    StAddrAck  = 3'd2,
    StWrite    = 3'd3,
    StWriteAck = 3'd4,
    StRead     = 3'd5,
    StReadAck  = 3'd6,
    StWaitStop = 3'd7
  } i2cs_state_t;

endpackage

// File: rtl/btzk_i2c_sync_edge.sv
// Multi-stage synchronizer for an asynchronous bus line with registered edge detection.
module btzk_i2c_sync_edge
  import btzk_i2c_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Reset to 1 so an idle (pulled-up) bus produces no edge after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/btzk_i2c_slave.sv
// I2C target: oversampled START/STOP detect, fixed address match, byte receive and transmit.
module btzk_i2c_slave
  import btzk_i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h55
) (
  input  logic                  btzk_i2cs_clk,
  input  logic                  btzk_i2cs_reset,
  input  logic                  btzk_i2cs_scl,
  inout  wire                   btzk_i2cs_sda,
  output logic [I2C_BYTE_W-1:0] btzk_i2cs_rx_data,
  output logic                  btzk_i2cs_rx_valid,
  input  logic [I2C_BYTE_W-1:0] btzk_i2cs_tx_data,
  output logic                  btzk_i2cs_tx_req,
  output logic                  btzk_i2cs_rw,
  output logic                  btzk_i2cs_busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  btzk_i2c_sync_edge u_scl_sync (
    .clk_i  (btzk_i2cs_clk),
    .rst_i  (btzk_i2cs_reset),
    .pin_i  (btzk_i2cs_scl),
    .level_o(scl_lvl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  btzk_i2c_sync_edge u_sda_sync (
    .clk_i  (btzk_i2cs_clk),
    .rst_i  (btzk_i2cs_reset),
    .pin_i  (btzk_i2cs_sda),
    .level_o(sda_lvl),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  i2cs_state_t           state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [I2C_BYTE_W-1:0] shift_q, shift_d;
  logic [I2C_BYTE_W-1:0] rx_data_q, rx_data_d;
  logic                  oe_q, oe_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rw_q, rw_d;
  logic                  busy_q, busy_d;
  logic                  load_q, load_d;
  logic                  tx_req;

  logic start_det, stop_det;
  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    oe_d       = oe_q;
    rx_valid_d = 1'b0;
    rw_d       = rw_q;
    busy_d     = busy_q;
    load_d     = load_q;
    tx_req     = 1'b0;
    if (stop_det) begin
      state_d = StIdle;
      cnt_d   = 3'd0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      load_d  = 1'b0;
    end else if (start_det) begin
      state_d = StAddr;
      cnt_d   = 3'd0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      load_d  = 1'b0;
    end else begin
      unique case (state_q)
        StAddr: if (scl_rise) begin
          shift_d = {shift_q[I2C_BYTE_W-2:0], sda_lvl};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (shift_q[I2C_ADDR_W-1:0] == SLAVE_ADDR) begin
              state_d = StAddrAck;
              rw_d    = sda_lvl;
              busy_d  = 1'b1;
              tx_req  = sda_lvl;
            end else begin
              state_d = StWaitStop;
            end
          end
        end
        // oe_q marks the second half of the ACK window: first fall drives, second releases.
        StAddrAck: if (scl_fall) begin
          if (!oe_q) begin
            oe_d = 1'b1;
          end else if (rw_q) begin
            state_d = StRead;
            shift_d = btzk_i2cs_tx_data;
            oe_d    = ~btzk_i2cs_tx_data[I2C_BYTE_W-1];
            cnt_d   = 3'd0;
          end else begin
            state_d = StWrite;
            oe_d    = 1'b0;
          end
        end
        StWrite: if (scl_rise) begin
          shift_d = {shift_q[I2C_BYTE_W-2:0], sda_lvl};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            rx_data_d  = {shift_q[I2C_BYTE_W-2:0], sda_lvl};
            rx_valid_d = 1'b1;
            state_d    = StWriteAck;
          end
        end
        StWriteAck: if (scl_fall) begin
          if (!oe_q) begin
            oe_d = 1'b1;
          end else begin
            oe_d    = 1'b0;
            state_d = StWrite;
          end
        end
        StRead: if (scl_fall) begin
          if (load_q) begin
            shift_d = btzk_i2cs_tx_data;
            oe_d    = ~btzk_i2cs_tx_data[I2C_BYTE_W-1];
            cnt_d   = 3'd0;
            load_d  = 1'b0;
          end else if (cnt_q == 3'd7) begin
            oe_d    = 1'b0;
            cnt_d   = 3'd0;
            state_d = StReadAck;
          end else begin
            shift_d = {shift_q[I2C_BYTE_W-2:0], 1'b0};
            oe_d    = ~shift_q[I2C_BYTE_W-2];
            cnt_d   = cnt_q + 3'd1;
          end
        end
        StReadAck: if (scl_rise) begin
          if (!sda_lvl) begin
            tx_req  = 1'b1;
            load_d  = 1'b1;
            state_d = StRead;
          end else begin
            state_d = StWaitStop;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge btzk_i2cs_clk) begin
    if (btzk_i2cs_reset) begin
      state_q    <= StIdle;
      cnt_q      <= 3'd0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      oe_q       <= 1'b0;
      rx_valid_q <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      load_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      oe_q       <= oe_d;
      rx_valid_q <= rx_valid_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      load_q     <= load_d;
    end
  end

  assign btzk_i2cs_sda      = oe_q ? 1'b0 : 1'bz;
  assign btzk_i2cs_rx_data  = rx_data_q;
  assign btzk_i2cs_rx_valid = rx_valid_q;
  assign btzk_i2cs_tx_req   = tx_req & ~btzk_i2cs_reset;
  assign btzk_i2cs_rw       = rw_q;
  assign btzk_i2cs_busy     = busy_q;

endmodule

// File: tb/tb_btzk_i2c_slave.sv
// Directed bench: a behavioural bus master drives SCL/SDA and checks target responses.
module tb_btzk_i2c_slave;
  import btzk_i2c_pkg::*;

  localparam int Q = 50;  // quarter SCL period; SCL period = 20 clk

  logic       clk;
  logic       reset;
  logic       scl;
  logic       m_low;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic       rw;
  logic       busy;
  wire        sda;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  btzk_i2c_slave #(.SLAVE_ADDR(7'h55)) dut (
    .btzk_i2cs_clk     (clk),
    .btzk_i2cs_reset   (reset),
    .btzk_i2cs_scl     (scl),
    .btzk_i2cs_sda     (sda),
    .btzk_i2cs_rx_data (rx_data),
    .btzk_i2cs_rx_valid(rx_valid),
    .btzk_i2cs_tx_data (tx_data),
    .btzk_i2cs_tx_req  (tx_req),
    .btzk_i2cs_rw      (rw),
    .btzk_i2cs_busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int rx_cnt   = 0;
  int tx_cnt   = 0;
  int drv_cnt  = 0;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) rx_cnt++;
    if (tx_req === 1'b1) tx_cnt++;
    if (sda === 1'b0 && !m_low) drv_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    m_low = ~b; #Q; scl = 1'b1; #Q; #Q; scl = 1'b0; #Q;
  endtask

  task automatic recv_bit(output logic b);
    m_low = 1'b0; #Q; scl = 1'b1; #Q; b = sda; #Q; scl = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(ack);
  endtask

  task automatic read_byte(input logic nack, input logic [7:0] next_tx, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) recv_bit(d[i]);
    m_low = ~nack; #Q; scl = 1'b1; #Q;
    tx_data = next_tx;
    #Q; scl = 1'b0; #Q;
  endtask

  task automatic start_cond();
    #Q; m_low = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic rstart_cond();
    m_low = 1'b0; #Q; scl = 1'b1; #Q; m_low = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic stop_cond();
    m_low = 1'b1; #Q; scl = 1'b1; #Q; m_low = 1'b0; #Q;
  endtask

  logic       ack;
  logic [7:0] d;
  int         rx0, tx0, drv0;

  initial begin
    reset = 1'b1; scl = 1'b1; m_low = 1'b0; tx_data = 8'h00;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_tx_req", 32'(tx_req), 32'h0);
    check("rst_rw", 32'(rw), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_sda", 32'(sda), 32'h1);

    // Write 0x55/W, 0xAD, STOP with busy-release timing.
    rx0 = rx_cnt;
    start_cond();
    write_byte(8'hAA, ack);
    check("w_addr_ack", 32'(ack), 32'h0);
    check("w_busy", 32'(busy), 32'h1);
    check("w_rw", 32'(rw), 32'h0);
    write_byte(8'hAD, ack);
    check("w_data_ack", 32'(ack), 32'h0);
    check("w_rx_data", 32'(rx_data), 32'hAD);
    check("w_rx_cnt", 32'(rx_cnt - rx0), 32'd1);
    m_low = 1'b1; #Q; scl = 1'b1; #Q;
    @(negedge clk);
    m_low = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("w_busy_2clk", 32'(busy), 32'h1);
    @(posedge clk); #1;
    check("w_busy_3clk", 32'(busy), 32'h0);
    @(negedge clk); #Q;

    // Wrong address: target stays silent.
    rx0 = rx_cnt; drv0 = drv_cnt;
    start_cond();
    write_byte(8'hA8, ack);
    check("na_addr_nack", 32'(ack), 32'h1);
    check("na_busy", 32'(busy), 32'h0);
    write_byte(8'hAD, ack);
    check("na_data_nack", 32'(ack), 32'h1);
    check("na_busy2", 32'(busy), 32'h0);
    check("na_rx_cnt", 32'(rx_cnt - rx0), 32'd0);
    check("na_drive", 32'(drv_cnt - drv0), 32'd0);
    stop_cond();

    // Read 0x55/R: 0x3C then 0xC3, ACK then NACK.
    @(negedge clk);
    tx_data = 8'h3C; tx0 = tx_cnt;
    start_cond();
    write_byte(8'hAB, ack);
    check("r_addr_ack", 32'(ack), 32'h0);
    check("r_rw", 32'(rw), 32'h1);
    check("r_tx_req1", 32'(tx_cnt - tx0), 32'd1);
    read_byte(1'b0, 8'hC3, d);
    check("r_byte1", 32'(d), 32'h3C);
    check("r_tx_req2", 32'(tx_cnt - tx0), 32'd2);
    read_byte(1'b1, 8'hC3, d);
    check("r_byte2", 32'(d), 32'hC3);
    check("r_tx_req_total", 32'(tx_cnt - tx0), 32'd2);
    repeat (5) @(negedge clk);
    check("r_sda_released", 32'(sda), 32'h1);
    check("r_state_wait", 32'(dut.state_q), 32'(StWaitStop));
    stop_cond();
    check("r_busy_after_stop", 32'(busy), 32'h0);

    // Write 0x12, repeated START, read back.
    @(negedge clk);
    rx0 = rx_cnt;
    start_cond();
    write_byte(8'hAA, ack);
    check("rs_rw0", 32'(rw), 32'h0);
    write_byte(8'h12, ack);
    check("rs_data_ack", 32'(ack), 32'h0);
    check("rs_rx_data", 32'(rx_data), 32'h12);
    tx_data = 8'h5A;
    rstart_cond();
    write_byte(8'hAB, ack);
    check("rs_addr2_ack", 32'(ack), 32'h0);
    check("rs_rw1", 32'(rw), 32'h1);
    check("rs_busy", 32'(busy), 32'h1);
    check("rs_rx_cnt", 32'(rx_cnt - rx0), 32'd1);
    read_byte(1'b1, 8'h5A, d);
    check("rs_read", 32'(d), 32'h5A);
    stop_cond();

    // STOP after 4 bits of a data byte.
    @(negedge clk);
    rx0 = rx_cnt;
    start_cond();
    write_byte(8'hAA, ack);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    stop_cond();
    repeat (5) @(negedge clk);
    check("ps_state", 32'(dut.state_q), 32'(StIdle));
    check("ps_rx_cnt", 32'(rx_cnt - rx0), 32'd0);
    check("ps_sda", 32'(sda), 32'h1);
    check("ps_rx_data", 32'(rx_data), 32'h12);

    // Reset asserted while the address ACK is being driven.
    @(negedge clk);
    start_cond();
    for (int i = 7; i >= 0; i--) send_bit(((8'hAB >> i) & 8'h01) != 0);
    check("ra_ack_drive", 32'(sda), 32'h0);
    check("ra_busy_pre", 32'(busy), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("ra_sda", 32'(sda), 32'h1);
    check("ra_rx_data", 32'(rx_data), 32'h00);
    check("ra_rx_valid", 32'(rx_valid), 32'h0);
    check("ra_tx_req", 32'(tx_req), 32'h0);
    check("ra_rw", 32'(rw), 32'h0);
    check("ra_busy", 32'(busy), 32'h0);
    check("ra_state", 32'(dut.state_q), 32'(StIdle));
    @(negedge clk);
    reset = 1'b0;
    scl = 1'b1;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
